// File: rtl/alu_pkg.sv
// Shared ALU definitions.
//   state_e : sequencer states for the byte-serial wide adder
//   BYTE_W  : width of one adder slice
//   OP_ADD / OP_SUB : encoding of the op_sub select bit
package alu_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rca_8.sv
// 8-bit ripple-carry adder slice.
//   a_i, b_i : byte operands
//   cin_i    : carry in
//   sum_o    : byte sum
//   cout_o   : carry out of bit 7
module rca_8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);

    logic carry;

    always_comb begin
        carry = cin_i;
        sum_o = '0;
        for (int i = 0; i < 8; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end

endmodule

// File: rtl/wide_add_seq.sv
// Byte-serial WIDTH-bit add/subtract using a single shared rca_8 slice.
// Operands are processed LSB byte first, one byte per clock, with a
// registered carry linking the slices.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   start_i, op_sub_i : request and operation select (sampled when ready_o)
//   a_i, b_i          : operands (sampled with start_i)
//   ready_o / busy_o  : IDLE / RUN indicators
//   done_o            : one-cycle pulse, result and flags valid from then on
//   result_o, cout_o, overflow_o, zero_o : registered result and flags
module wide_add_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             op_sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             zero_o
);

    localparam int unsigned N    = WIDTH / BYTE_W;
    localparam int unsigned IdxW = $clog2(N);

    state_e                    state_q;
    logic [WIDTH-1:0]          a_q;
    logic [WIDTH-1:0]          b_q;
    logic                      carry_q;
    logic [IdxW-1:0]           idx_q;
    // Only the upper WIDTH-BYTE_W bits need storing; the newest byte comes
    // straight from the adder when the final result is assembled.
    logic [WIDTH-BYTE_W-1:0]   res_sh_q;

    logic                      ready_q;
    logic                      busy_q;
    logic                      done_q;
    logic [WIDTH-1:0]          result_q;
    logic                      cout_q;
    logic                      overflow_q;
    logic                      zero_q;

    logic [BYTE_W-1:0]         slice_sum;
    logic                      slice_cout;
    logic [WIDTH-1:0]          res_next;
    logic                      last_byte;

    rca_8 u_rca_8 (
        .a_i    (a_q[BYTE_W-1:0]),
        .b_i    (b_q[BYTE_W-1:0]),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    assign res_next  = {slice_sum, res_sh_q};
    assign last_byte = (idx_q == IdxW'(N - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            res_sh_q   <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        // Subtract as a + ~b + 1: invert b and seed the carry.
                        b_q     <= (op_sub_i == OP_SUB) ? ~b_i : b_i;
                        carry_q <= op_sub_i;
                        idx_q   <= '0;
                        state_q <= RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    a_q      <= {{BYTE_W{1'b0}}, a_q[WIDTH-1:BYTE_W]};
                    b_q      <= {{BYTE_W{1'b0}}, b_q[WIDTH-1:BYTE_W]};
                    res_sh_q <= res_next[WIDTH-1:BYTE_W];
                    carry_q  <= slice_cout;
                    idx_q    <= idx_q + 1'b1;
                    if (last_byte) begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        result_q   <= res_next;
                        cout_q     <= slice_cout;
                        // On the last byte, bit 7 of the slice is the word MSB.
                        overflow_q <= (a_q[BYTE_W-1] == b_q[BYTE_W-1]) &&
                                      (slice_sum[BYTE_W-1] != a_q[BYTE_W-1]);
                        zero_q     <= (res_next == '0);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o    = ready_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign cout_o     = cout_q;
    assign overflow_o = overflow_q;
    assign zero_o     = zero_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Scoreboard bench for wide_add_seq (WIDTH=32): stimulus pushes expected
// results, a negedge monitor pops and compares whenever done_o is seen.
module tb_wide_add_seq;

    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         ov;
        logic         z;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
    logic         zero;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;

    exp_t exp_q[$];
    int   done_cyc[$];

    wide_add_seq #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .op_sub_i   (op_sub),
        .a_i        (a),
        .b_i        (b),
        .ready_o    (ready),
        .busy_o     (busy),
        .done_o     (done),
        .result_o   (result),
        .cout_o     (cout),
        .overflow_o (overflow),
        .zero_o     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: compare every done pulse against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_cnt++;
            done_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 result=%h", result);
            end else begin
                e = exp_q.pop_front();
                chk("result",   result,               e.res);
                chk("cout",     {{(W-1){1'b0}}, cout},     {{(W-1){1'b0}}, e.c});
                chk("overflow", {{(W-1){1'b0}}, overflow}, {{(W-1){1'b0}}, e.ov});
                chk("zero",     {{(W-1){1'b0}}, zero},     {{(W-1){1'b0}}, e.z});
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
    endtask

    // Wait for done (bounded); returns negedges elapsed since the call.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 40);
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=0 required=1");
        end
    endtask

    task automatic run_op(input logic sub, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] r, input logic c, input logic ov,
                          input logic z);
        exp_t e;
        int   lat;
        wait_ready();
        e.res = r; e.c = c; e.ov = ov; e.z = z;
        exp_q.push_back(e);
        start = 1'b1; op_sub = sub; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        // One negedge already consumed above: total start-to-done is lat+1.
        chk("latency", W'(lat + 1), W'(5));
    endtask

    initial begin
        int   lat;
        int   base;
        exp_t e;

        rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready",  {31'b0, ready},    32'd1);
        chk("rst_busy",   {31'b0, busy},     32'd0);
        chk("rst_done",   {31'b0, done},     32'd0);
        chk("rst_result", result,            32'd0);
        chk("rst_flags",  {29'b0, cout, overflow, zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors: sub, a, b, result, cout, overflow, zero
        run_op(1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_op(1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op(1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_op(1'b1, 32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0);
        run_op(1'b1, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

        // start pulses during RUN and DONE must be ignored.
        wait_ready();
        base = done_cnt;
        e.res = 32'h0000_0003; e.c = 1'b0; e.ov = 1'b0; e.z = 1'b0;
        exp_q.push_back(e);
        start = 1'b1; op_sub = 1'b0; a = 32'h1; b = 32'h2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op_sub = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1111_1111;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        start = 1'b1;                     // pulse while in DONE
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("ignored_start_done_count", W'(done_cnt - base), W'(1));

        // start held high: one operation every 6 cycles.
        wait_ready();
        base = done_cnt;
        e.res = 32'h0000_0002; e.c = 1'b0; e.ov = 1'b0; e.z = 1'b0;
        repeat (3) exp_q.push_back(e);
        start = 1'b1; op_sub = 1'b0; a = 32'h1; b = 32'h1;
        lat = 0;
        while (done_cnt - base < 3 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("held_start_count", W'(done_cnt - base), W'(3));
        if (done_cyc.size() >= 3) begin
            chk("held_interval_1", W'(done_cyc[done_cyc.size()-2] - done_cyc[done_cyc.size()-3]), W'(6));
            chk("held_interval_2", W'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]), W'(6));
        end
        repeat (3) @(negedge clk);

        // Reset in the second RUN cycle aborts and clears outputs.
        run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        wait_ready();
        base = done_cnt;
        start = 1'b1; op_sub = 1'b0; a = 32'h0000_0010; b = 32'h0000_0020;
        @(negedge clk);                   // first RUN cycle
        start = 1'b0;
        chk("abort_busy_before", {31'b0, busy}, 32'd1);
        @(negedge clk);                   // second RUN cycle
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready",  {31'b0, ready},  32'd1);
        chk("abort_busy",   {31'b0, busy},   32'd0);
        chk("abort_done",   {31'b0, done},   32'd0);
        chk("abort_result", result,          32'd0);
        chk("abort_flags",  {29'b0, cout, overflow, zero}, 32'd0);
        repeat (8) @(negedge clk);
        chk("abort_no_done", W'(done_cnt - base), W'(0));
        run_op(1'b0, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", W'(exp_q.size()), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/wide_add_seq.md
# wide_add_seq

Multi-cycle sequencer that performs WIDTH-bit add and subtract by time-multiplexing a single `rca_8` adder, one byte per clock, least-significant byte first. A registered carry links the byte slices. It sits between the ALU control logic and the 8-bit adder and gives wide arithmetic at the area cost of one byte slice. It uses a start/done handshake and produces registered result, carry, overflow and zero flags.

## Interface
- `WIDTH`, default 32: operand and result width. Must be a multiple of 8 and at least 16. N = WIDTH/8 byte steps.

- `clk` input 1: single clock; all state is updated on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: request an operation. Sampled only when `ready`=1.
- `op_sub` input 1: 0 selects a+b; 1 selects a−b. Sampled with `start`.
- `a` input WIDTH: first operand. Sampled with `start`.
- `b` input WIDTH: second operand. Sampled with `start`.
- `ready` output 1: high in IDLE only.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle pulse when the result is valid.
- `result` output WIDTH: sum or difference, held until the next `done`.
- `cout` output 1: final carry out. For subtract, 1 means no borrow.
- `overflow` output 1: two's-complement signed overflow.
- `zero` output 1: result == 0.

## Operation
- State machine with three states:
  - IDLE → RUN on `start`.
  - RUN → RUN while byte index < N−1.
  - RUN → DONE at index N−1.
  - DONE → IDLE unconditionally.
- Accept in IDLE with `start`=1:
  - latch `a` into the A shift register;
  - latch `b` into the B shift register, inverted if `op_sub`;
  - load the carry register with `op_sub`;
  - clear the byte index.
- Each RUN cycle:
  - `rca_8` adds A[7:0], B[7:0] and the carry register;
  - the sum byte shifts into the top of the result shift register;
  - the carry register takes the adder `cout`;
  - A and B shift right by 8.
- On the last byte, the MSB of the shifted operands is captured for overflow: overflow = (a_msb == b_eff_msb) && (sum_msb != a_msb).
- Output registers `result`, `cout`, `overflow` and `zero` load only on the RUN→DONE edge. They are stable at all other times.
- `start` while in RUN or DONE is ignored and does not queue.
- Reset behaviour:
  - reset clears state to IDLE;
  - all outputs go to 0 except `ready`, which is 1;
  - internal registers go to 0.
- Reset during RUN aborts the operation, and the output registers clear.

## Timing
- Start accepted at edge E0. `busy` is high from E0 through E(N−1).
- `done` is high for one cycle after edge EN. Latency is N+1 clocks from the accepting edge to `done`; for WIDTH=32 this is 5.
- `ready` returns high one cycle after `done`. Back-to-back throughput is one operation per N+2 cycles.
- The earliest next accept is the edge at the end of the first IDLE cycle.
- Flags and `result` change only in the same cycle that `done` rises.
- Outputs are registered. The only combinational path is inside the single `rca_8` instance, giving an 8-bit ripple per cycle.

## Structure
- Shared package `alu_pkg`:
  - state enum {IDLE, RUN, DONE};
  - constant `BYTE_W` = 8;
  - op-encoding constants `OP_ADD` = 0, `OP_SUB` = 1.
- One sub-module: the existing `rca_8`, instantiated exactly once and never replicated.
- Index counter width is clog2(N).

## Test plan
- WIDTH=32, add 0x0000_00FF + 0x0000_0001 → result 0x0000_0100, cout 0, overflow 0, zero 0. Checks that the carry crosses a byte boundary. `done` arrives 5 cycles after start.
- Add 0xFFFF_FFFF + 0x0000_0001 → result 0, cout 1, zero 1, overflow 0.
- Add 0x7FFF_FFFF + 0x0000_0001 → result 0x8000_0000, overflow 1, cout 0.
- Sub 0x0000_0005 − 0x0000_0007 → result 0xFFFF_FFFE, cout 0 (borrow), overflow 0. Sub 0x8000_0000 − 1 → 0x7FFF_FFFF, overflow 1.
- Pulse `start` again during RUN with different operands → ignored; the first result is correct. `start` held high continuously → an operation every 6 cycles.
- Assert `rst` in the second RUN cycle → next cycle: `ready`=1, `busy`/`done`=0, `result`=0. A new op then completes normally.
